// File: rtl/inverter_test_sequencer.sv
// -----------------------------------------------------------------------------
// inverter_test_sequencer
//
// Runs one automated test pass over a WIDTH-channel level-translator/inverter
// board. A fixed sequence of patterns (all zeros, all ones, walking one,
// walking zero) is driven onto the board inputs. The board outputs are
// synchronised and compared against the expected level. The per-channel
// mismatch vector feeds an external consecutive-mismatch counter bank. When
// the pass ends, the bank's sticky flags are captured as a fail mask.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a pass (honoured only in IDLE)
//   abort      abandons a pass in progress (ignored in IDLE)
//   sense      board outputs, asynchronous to clk
//   drive      board inputs (registered)
//   diff       per-channel mismatch to the counter bank (registered)
//   cnt_rst    synchronous clear to the counter bank (registered)
//   flag       sticky per-channel fail flags from the counter bank
//   busy       high while a pass is in progress
//   done       one-cycle pulse when a completed pass returns to IDLE
//   pass       1 when the last completed pass had an all-zero fail mask
//   fail_mask  flag snapshot from the last completed pass
//   pat_idx    index of the pattern currently driven
// -----------------------------------------------------------------------------
module inverter_test_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 16,
    parameter int DWELL  = 64,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] sense,
    output logic [WIDTH-1:0] drive,
    output logic [WIDTH-1:0] diff,
    output logic             cnt_rst,
    input  logic [WIDTH-1:0] flag,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] fail_mask,
    output logic [7:0]       pat_idx
);

    localparam int          NPAT      = 2 + 2 * WIDTH;
    localparam logic [7:0]  LAST_PAT  = 8'(NPAT - 1);
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);
    localparam logic [15:0] DWELL_LD  = 16'(DWELL - 1);
    localparam logic [15:0] FLUSH_LD  = 16'd1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DRIVE,
        SAMPLE,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [15:0]      timer;
    logic [15:0]      timer_n;
    logic [7:0]       pat_n;
    logic             done_n;
    logic             latch_n;
    logic [WIDTH-1:0] sense_meta;
    logic [WIDTH-1:0] sense_s;
    logic [WIDTH-1:0] expect_level;

    // Pattern table: 0 = all zeros, 1 = all ones, then a walking one across
    // every channel, then a walking zero across every channel.
    function automatic logic [WIDTH-1:0] pattern_of(input logic [7:0] idx);
        logic [WIDTH-1:0] p;
        int               i;
        i = int'(idx);
        p = '0;
        if (i == 1) begin
            p = '1;
        end else if (i >= 2 && i < WIDTH + 2) begin
            for (int b = 0; b < WIDTH; b++) begin
                p[b] = (b == i - 2);
            end
        end else if (i >= WIDTH + 2 && i < NPAT) begin
            for (int b = 0; b < WIDTH; b++) begin
                p[b] = (b != i - WIDTH - 2);
            end
        end
        return p;
    endfunction

    // The level each board output should show for the currently driven
    // pattern, depending on whether the board inverts or buffers.
    assign expect_level = (INVERT != 0) ? ~drive : drive;

    assign busy = (state != IDLE);

    // Two-flop synchroniser for the asynchronous board outputs. SETTLE is at
    // least 3, so the synchronised value is current before comparison starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sense_meta <= '0;
            sense_s    <= '0;
        end else begin
            sense_meta <= sense;
            sense_s    <= sense_meta;
        end
    end

    // Next-state logic. The shared timer is loaded with (duration - 1) on
    // every state entry and the state advances when it reaches zero. Abort
    // is applied last so it overrides any advance and suppresses the
    // end-of-pass capture.
    always_comb begin
        state_n = state;
        timer_n = (timer != 16'd0) ? timer - 16'd1 : 16'd0;
        pat_n   = pat_idx;
        done_n  = 1'b0;
        latch_n = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    timer_n = 16'd0;
                    pat_n   = 8'd0;
                end
            end
            CLEAR: begin
                if (timer == 16'd0) begin
                    state_n = DRIVE;
                    timer_n = SETTLE_LD;
                end
            end
            DRIVE: begin
                if (timer == 16'd0) begin
                    state_n = SAMPLE;
                    timer_n = DWELL_LD;
                end
            end
            SAMPLE: begin
                if (timer == 16'd0) begin
                    if (pat_idx == LAST_PAT) begin
                        state_n = FLUSH;
                        timer_n = FLUSH_LD;
                    end else begin
                        state_n = DRIVE;
                        timer_n = SETTLE_LD;
                        pat_n   = pat_idx + 8'd1;
                    end
                end
            end
            FLUSH: begin
                if (timer == 16'd0) begin
                    state_n = DONE;
                    timer_n = 16'd0;
                end
            end
            DONE: begin
                state_n = IDLE;
                timer_n = 16'd0;
                done_n  = 1'b1;
                latch_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                timer_n = 16'd0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            timer_n = 16'd0;
            done_n  = 1'b0;
            latch_n = 1'b0;
        end
    end

    // State, timer and registered board-facing outputs. The outputs are
    // computed from the next state so they line up cycle-for-cycle with it.
    // diff uses the drive value already on the board, which is the same
    // pattern throughout its DRIVE and SAMPLE windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= 16'd0;
            pat_idx   <= 8'd0;
            drive     <= '0;
            diff      <= '0;
            cnt_rst   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            pat_idx <= pat_n;
            done    <= done_n;
            cnt_rst <= (state_n == CLEAR);
            if (state_n == DRIVE || state_n == SAMPLE) begin
                drive <= pattern_of(pat_n);
            end else begin
                drive <= '0;
            end
            if (state_n == SAMPLE) begin
                diff <= sense_s ^ expect_level;
            end else begin
                diff <= '0;
            end
            if (latch_n) begin
                fail_mask <= flag;
                pass      <= ~|flag;
            end
        end
    end

endmodule

// File: tb/tb_inverter_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inverter_test_sequencer
//
// Directed bench for inverter_test_sequencer with default parameters
// (WIDTH=8, SETTLE=16, DWELL=64, INVERT=1). The board is a loopback inverter
// with injectable stuck-high and glitch faults. A behavioural consecutive-
// mismatch counter bank (THRESHOLD=3) sits on diff/cnt_rst/flag.
// -----------------------------------------------------------------------------
module tb_inverter_test_sequencer;

    localparam int WIDTH     = 8;
    localparam int THRESHOLD = 3;
    localparam int PASS_LEN  = 1445;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] sense;
    logic [WIDTH-1:0] drive;
    logic [WIDTH-1:0] diff;
    logic             cnt_rst;
    logic [WIDTH-1:0] flag;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] fail_mask;
    logic [7:0]       pat_idx;

    logic [WIDTH-1:0] stuck_mask;
    logic [WIDTH-1:0] glitch_mask;
    logic [7:0]       bank_cnt [WIDTH];

    int checks;
    int errors;
    int cycles;

    int         cnt_rst_count;
    int         done_count;
    logic       diff_seen;
    logic [7:0] first_diff;
    logic [7:0] first_diff_pat;
    logic [7:0] pat_max;
    logic [7:0] prev_pat;
    logic       walk_bad;

    inverter_test_sequencer #(
        .WIDTH (WIDTH),
        .SETTLE(16),
        .DWELL (64),
        .INVERT(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .sense    (sense),
        .drive    (drive),
        .diff     (diff),
        .cnt_rst  (cnt_rst),
        .flag     (flag),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_mask(fail_mask),
        .pat_idx  (pat_idx)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback inverter board with a stuck-high overlay and a glitch overlay.
    assign sense = (~drive | stuck_mask) ^ glitch_mask;

    // Counter bank: a flag becomes sticky on the edge that sees the
    // THRESHOLD-th consecutive mismatch, giving one cycle of latency after
    // diff. cnt_rst clears counts and flags.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= '0;
            for (int c = 0; c < WIDTH; c++) bank_cnt[c] <= 8'd0;
        end else if (cnt_rst) begin
            flag <= '0;
            for (int c = 0; c < WIDTH; c++) bank_cnt[c] <= 8'd0;
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                if (diff[c]) begin
                    if (bank_cnt[c] < 8'd200) bank_cnt[c] <= bank_cnt[c] + 8'd1;
                    if (int'(bank_cnt[c]) >= THRESHOLD - 1) flag[c] <= 1'b1;
                end else begin
                    bank_cnt[c] <= 8'd0;
                end
            end
        end
    end

    // Pass observer on the falling edge: statistics restart whenever a start
    // is about to be accepted, then record diff activity, cnt_rst and done
    // pulses, and whether pat_idx only ever holds, steps by one or returns
    // to zero.
    always @(negedge clk) begin
        if (start && !busy) begin
            cnt_rst_count  <= 0;
            done_count     <= 0;
            diff_seen      <= 1'b0;
            first_diff     <= 8'd0;
            first_diff_pat <= 8'd0;
            pat_max        <= 8'd0;
            prev_pat       <= 8'd0;
            walk_bad       <= 1'b0;
        end else begin
            if (diff != 8'd0) begin
                diff_seen <= 1'b1;
                if (!diff_seen) begin
                    first_diff     <= diff;
                    first_diff_pat <= pat_idx;
                end
            end
            if (cnt_rst) cnt_rst_count <= cnt_rst_count + 1;
            if (done) done_count <= done_count + 1;
            if (pat_idx > pat_max) pat_max <= pat_idx;
            if (!(pat_idx == prev_pat || pat_idx == prev_pat + 8'd1 || pat_idx == 8'd0)) walk_bad <= 1'b1;
            prev_pat <= pat_idx;
        end
    end

    // One comparison point: counts it and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one pass. cycles counts clock edges from the edge that accepts
    // start (cycles=1) through the edge that raises done, so the state after
    // edge k is seen when cycles = k+1. Optional extras: a second start
    // request at restart_at, a channel-5 glitch starting at glitch_at for
    // glitch_len cycles, and spot checks of the driven pattern.
    task automatic applyStimulus(input int restart_at, input int glitch_at, input int glitch_len,
                                 input bit check_drive, output int pass_cycles);
        bit done_hit;
        done_hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        pass_cycles = 1;
        #1;
        start = 1'b0;
        while (!done_hit && pass_cycles < 3000) begin
            @(posedge clk);
            pass_cycles++;
            #1;
            start = (restart_at != 0 && pass_cycles == restart_at);
            if (glitch_len > 0 && pass_cycles == glitch_at) glitch_mask = 8'h20;
            if (glitch_len > 0 && pass_cycles == glitch_at + glitch_len) glitch_mask = 8'h00;
            if (check_drive) begin
                case (pass_cycles)
                    21:      checkOutput("drive_pat0", 32'(drive), 32'h00);
                    100:     checkOutput("drive_pat1", 32'(drive), 32'hFF);
                    251:     checkOutput("drive_walk1_bit1", 32'(drive), 32'h02);
                    1001:    checkOutput("drive_walk0_bit2", 32'(drive), 32'hFB);
                    1401:    checkOutput("drive_walk0_bit7", 32'(drive), 32'h7F);
                    default: ;
                endcase
            end
            if (done) done_hit = 1'b1;
        end
        start       = 1'b0;
        glitch_mask = 8'h00;
        checkOutput("busy_low_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_single_pulse", 32'(done), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        stuck_mask  = 8'h00;
        glitch_mask = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_drive", 32'(drive), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_cnt_rst", 32'(cnt_rst), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_fail_mask", 32'(fail_mask), 32'd0);
        checkOutput("rst_pat_idx", 32'(pat_idx), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] ideal loopback pass");
        applyStimulus(0, 0, 0, 1'b1, cycles);
        checkOutput("ideal_cycles", 32'(cycles), 32'(PASS_LEN));
        checkOutput("ideal_pass", 32'(pass), 32'd1);
        checkOutput("ideal_fail_mask", 32'(fail_mask), 32'h00);
        checkOutput("ideal_diff_seen", 32'(diff_seen), 32'd0);
        checkOutput("ideal_cnt_rst_pulses", 32'(cnt_rst_count), 32'd1);
        checkOutput("ideal_pat_max", 32'(pat_max), 32'd17);

        $display("[TB] channel 3 stuck high");
        stuck_mask = 8'h08;
        applyStimulus(0, 0, 0, 1'b0, cycles);
        checkOutput("stuck_cycles", 32'(cycles), 32'(PASS_LEN));
        checkOutput("stuck_fail_mask", 32'(fail_mask), 32'h08);
        checkOutput("stuck_pass", 32'(pass), 32'd0);
        checkOutput("stuck_first_diff", 32'(first_diff), 32'h08);
        checkOutput("stuck_first_diff_pat", 32'(first_diff_pat), 32'd1);
        checkOutput("stuck_pat_max", 32'(pat_max), 32'd17);
        checkOutput("stuck_pat_walk", 32'(walk_bad), 32'd0);
        stuck_mask = 8'h00;

        $display("[TB] short and long glitch on channel 5");
        applyStimulus(0, 271, 2, 1'b0, cycles);
        checkOutput("glitch2_pass", 32'(pass), 32'd1);
        checkOutput("glitch2_fail_mask", 32'(fail_mask), 32'h00);
        checkOutput("glitch2_first_diff", 32'(first_diff), 32'h20);
        applyStimulus(0, 271, 4, 1'b0, cycles);
        checkOutput("glitch4_pass", 32'(pass), 32'd0);
        checkOutput("glitch4_fail_mask", 32'(fail_mask), 32'h20);

        $display("[TB] abort during pattern 7 sample window");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1;
        start = 1'b0;
        while (cycles < 600) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        checkOutput("abort_pat_idx", 32'(pat_idx), 32'd7);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_drive", 32'(drive), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        checkOutput("abort_keep_mask", 32'(fail_mask), 32'h20);
        checkOutput("abort_keep_pass", 32'(pass), 32'd0);
        applyStimulus(0, 0, 0, 1'b0, cycles);
        checkOutput("after_abort_cycles", 32'(cycles), 32'(PASS_LEN));
        checkOutput("after_abort_cnt_rst_pulses", 32'(cnt_rst_count), 32'd1);
        checkOutput("after_abort_pass", 32'(pass), 32'd1);
        checkOutput("after_abort_fail_mask", 32'(fail_mask), 32'h00);

        $display("[TB] start re-asserted while busy");
        stuck_mask = 8'h08;
        applyStimulus(300, 0, 0, 1'b0, cycles);
        checkOutput("restart_cycles", 32'(cycles), 32'(PASS_LEN));
        checkOutput("restart_cnt_rst_pulses", 32'(cnt_rst_count), 32'd1);
        checkOutput("restart_fail_mask", 32'(fail_mask), 32'h08);
        stuck_mask = 8'h00;

        $display("[TB] reset during pattern 2 drive window");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1;
        start = 1'b0;
        while (cycles < 166) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        checkOutput("pre_reset_drive", 32'(drive), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_drive", 32'(drive), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_pat_idx", 32'(pat_idx), 32'd0);
        checkOutput("async_rst_fail_mask", 32'(fail_mask), 32'd0);
        checkOutput("async_rst_pass", 32'(pass), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus(0, 0, 0, 1'b0, cycles);
        checkOutput("post_reset_cycles", 32'(cycles), 32'(PASS_LEN));
        checkOutput("post_reset_pass", 32'(pass), 32'd1);
        checkOutput("post_reset_fail_mask", 32'(fail_mask), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inverter_test_sequencer.md
Name: inverter_test_sequencer

Overview:
- Runs one automated test pass over a WIDTH-channel level-translator/inverter board.
- Drives a fixed pattern sequence onto the DUT inputs and synchronises the DUT outputs.
- Produces a per-channel mismatch vector for the external per-channel consecutive-mismatch counter bank, and controls its clear.
- After the pass, latches that bank's sticky flags as a fail mask with a pass/fail summary.

Parameters:
- WIDTH, 8: number of DUT channels; must match the counter bank width.
- SETTLE, 16: cycles each pattern is driven before comparison starts; legal range 3..255, to cover the 2-flop synchroniser.
- DWELL, 64: compare-window cycles per pattern; legal range 1..65535.
- INVERT, 1: 1 = expected = ~drive (inverting DUT); 0 = expected = drive (buffering DUT).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a pass; honoured only in IDLE.
- abort  in  1  aborts a pass in progress; ignored in IDLE.
- sense  in  WIDTH  DUT outputs; asynchronous to clk.
- drive  out  WIDTH  DUT inputs.
- diff  out  WIDTH  per-channel mismatch to the counter bank.
- cnt_rst  out  1  synchronous clear to the counter bank.
- flag  in  WIDTH  sticky per-channel fail flags from the counter bank; 1-cycle latency after diff.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when a completed pass returns to IDLE.
- pass  out  1  1 when the last completed pass had fail_mask == 0.
- fail_mask  out  WIDTH  flag snapshot from the last completed pass.
- pat_idx  out  8  index of the pattern currently driven.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; drive = 0, diff = 0, cnt_rst = 0, busy = 0, done = 0, pass = 0, fail_mask = 0, pat_idx = 0.
  - Synchroniser flops and all counters cleared.
- Sense path: 2-flop synchroniser sense_s.
  - diff = sense_s ^ (INVERT ? ~drive : drive), registered.
  - diff is forced to 0 in every state except SAMPLE.
- Pattern sequence: NPAT = 2 + 2*WIDTH patterns, in this order:
  - idx 0: all zeros.
  - idx 1: all ones.
  - idx 2..WIDTH+1: walking one, bit (idx-2).
  - idx WIDTH+2..2*WIDTH+1: walking zero, bit (idx-WIDTH-2).
- States:
  - IDLE: drive = 0. start=1 → CLEAR.
  - CLEAR, 1 cycle: cnt_rst = 1, pat_idx = 0 → DRIVE.
  - DRIVE, SETTLE cycles: drive = pattern(pat_idx), diff = 0 → SAMPLE.
  - SAMPLE, DWELL cycles: diff live.
    - If pat_idx < NPAT-1: pat_idx+1 → DRIVE.
    - Else → FLUSH.
  - FLUSH, 2 cycles: diff = 0, covers counter-bank latency → DONE.
  - DONE, 1 cycle: fail_mask <= flag, pass <= ~|flag → IDLE; done pulses on the IDLE-entry cycle.
- Flags are not cleared between patterns; the counter bank accumulates over the whole pass. The diff=0 gaps restart the consecutive counts.
- Timing: the pass length from the start cycle to the done pulse is 1 + NPAT*(SETTLE+DWELL) + 2 + 1 + 1 cycles.
- abort=1 in any non-IDLE state → IDLE next cycle:
  - drive = 0, diff = 0.
  - No done pulse; fail_mask and pass retain their previous values.
  - abort takes priority over all state advances.
- start in a non-IDLE state is ignored. start and abort together in IDLE: the pass starts.
- Timer: one 16-bit down-counter, reloaded on each state entry.
- drive, diff and cnt_rst are all registered (glitch-free outputs to the board).

Test Plan:
- Ideal inverter loopback (sense = ~drive, INVERT=1, counter THRESHOLD=3, WIDTH=8, SETTLE=16, DWELL=64) -> done after 1+18*80+4 = 1445 cycles; pass=1, fail_mask=0x00; diff never nonzero.
- Channel 3 stuck high -> fail_mask=0x08, pass=0. First nonzero diff is 0x08, seen in pattern idx 1 SAMPLE. pat_idx walks 0..17.
- 2-cycle glitch on channel 5 inside one SAMPLE window, otherwise ideal -> pass=1. Same stimulus with a 4-cycle glitch -> fail_mask=0x20.
- abort during pattern 7 SAMPLE -> next cycle IDLE, busy=0, drive=0, no done; fail_mask/pass keep the prior pass values. A new start then runs a full pass with cnt_rst pulsed once.
- start re-asserted while busy -> no restart; done occurs at the original 1445-cycle mark.
- rst_n low mid-DRIVE -> all outputs zero immediately (async), IDLE. After release, start yields a normal pass.
